// File: rtl/melody_sequencer_if.sv
// Control, ROM and synthesizer-facing signals of the melody sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface melody_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [10:0]       rom_data;
  logic [6:0]        hp;
  logic              active;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, hp, active, busy, done
  );

  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, hp, active, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a tune from a combinational ROM: each word {hp, dur} drives the
// synthesizer for dur tempo ticks, followed by GAP_TICKS silent ticks.
module melody_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1
) (
  input logic               clk,
  input logic               rst_n,
  melody_sequencer_if.slave bus
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int GW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [6:0]        note_hp;
  logic              act;
  logic              done_p;
  logic [DW-1:0]     div;
  logic [3:0]        dur_ctr;
  logic [GW-1:0]     gap_ctr;
  logic              wrap_pend;

  logic [6:0] w_hp;
  logic [3:0] w_dur;
  logic       tick;
  logic       last_addr;

  assign w_hp      = bus.rom_data[10:4];
  assign w_dur     = bus.rom_data[3:0];
  assign tick      = (div == DW'(TICK_DIV - 1));
  assign last_addr = (addr == '1);

  assign bus.rom_addr = addr;
  assign bus.hp       = note_hp;
  assign bus.active   = act;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      note_hp   <= '0;
      act       <= 1'b0;
      done_p    <= 1'b0;
      div       <= '0;
      dur_ctr   <= '0;
      gap_ctr   <= '0;
      wrap_pend <= 1'b0;
    end else begin
      done_p <= 1'b0;
      if (bus.stop) begin
        // Abort: no done pulse, hp deliberately left as is.
        state     <= IDLE;
        act       <= 1'b0;
        addr      <= '0;
        wrap_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            addr <= '0;
            act  <= 1'b0;
            if (bus.start) state <= FETCH;
          end
          FETCH: begin
            if (w_dur != 4'd0) begin
              note_hp <= w_hp;
              dur_ctr <= w_dur;
              div     <= '0;
              act     <= (w_hp != 7'd0);
              state   <= PLAY;
            end else if (bus.loop_en && addr != '0) begin
              addr <= '0;
            end else begin
              // Marker at address 0 ends even when looping, avoiding an empty spin.
              done_p <= 1'b1;
              addr   <= '0;
              state  <= IDLE;
            end
          end
          PLAY: begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
              dur_ctr <= dur_ctr - 4'd1;
              if (dur_ctr == 4'd1) begin
                act  <= 1'b0;
                addr <= addr + 1'b1;
                div  <= '0;
                if (GAP_TICKS > 0) begin
                  gap_ctr   <= GW'(GAP_TICKS);
                  wrap_pend <= last_addr;
                  state     <= GAP;
                end else if (last_addr && !bus.loop_en) begin
                  done_p <= 1'b1;
                  state  <= IDLE;
                end else begin
                  state <= FETCH;
                end
              end
            end
          end
          GAP: begin
            act <= 1'b0;
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
              gap_ctr <= gap_ctr - 1'b1;
              if (gap_ctr == GW'(1)) begin
                wrap_pend <= 1'b0;
                // Address wrapped past the top of the ROM: end of tune unless looping.
                if (wrap_pend && !bus.loop_en) begin
                  done_p <= 1'b1;
                  state  <= IDLE;
                end else begin
                  state <= FETCH;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a cycle-level timing model of each tune is queued at
// start and compared against the sequencer outputs every cycle.
module tb_melody_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  melody_sequencer_if #(.ADDR_W(5)) bus_a ();
  melody_sequencer_if #(.ADDR_W(2)) bus_b ();

  melody_sequencer #(.ADDR_W(5), .TICK_DIV(4), .GAP_TICKS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  melody_sequencer #(.ADDR_W(2), .TICK_DIV(4), .GAP_TICKS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  logic [10:0] rom_a [32];
  logic [10:0] rom_b [4];
  assign bus_a.rom_data = rom_a[bus_a.rom_addr];
  assign bus_b.rom_data = rom_b[bus_b.rom_addr];

  // entry = {active, hp[6:0], busy, done, rom_addr[4:0]}
  logic [14:0] q[$];
  logic [6:0]  last_hp_a = 7'd0;
  logic [6:0]  last_hp_b = 7'd0;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] obs(input bit sel);
    if (sel) return {bus_b.active, bus_b.hp, bus_b.busy, bus_b.done, 3'b000, bus_b.rom_addr};
    return {bus_a.active, bus_a.hp, bus_a.busy, bus_a.done, bus_a.rom_addr};
  endfunction

  function automatic logic [10:0] w(input logic [6:0] h, input logic [3:0] d);
    return {h, d};
  endfunction

  task automatic push(input logic a, input logic [6:0] h, input logic b,
                      input logic d, input int ad);
    q.push_back({a, h, b, d, 5'(ad)});
  endtask

  // Expected per-cycle trace from the first sample after the start edge.
  task automatic gen(input bit sel, input bit loop, input int max_n);
    int addr = 0;
    int nw = sel ? 4 : 32;
    int na;
    logic [6:0] h = sel ? last_hp_b : last_hp_a;
    logic [10:0] wd;
    push(0, h, 1, 0, 0);
    while (q.size() < max_n) begin
      wd = sel ? rom_b[addr] : rom_a[addr];
      if (wd[3:0] == 4'd0) begin
        if (loop && addr != 0) begin
          addr = 0;
          push(0, h, 1, 0, 0);
          continue;
        end
        push(0, h, 0, 1, 0);
        break;
      end
      h = wd[10:4];
      repeat (int'(wd[3:0]) * 4) push(h != 7'd0, h, 1, 0, addr);
      na = (addr + 1) % nw;
      repeat (4) push(0, h, 1, 0, na);
      addr = na;
      if (addr == 0 && !loop) begin
        push(0, h, 0, 1, 0);
        break;
      end
      push(0, h, 1, 0, addr);
    end
    repeat (3) push(0, h, 0, 0, 0);
    while (q.size() > max_n) void'(q.pop_back());
  endtask

  task automatic kick(input bit sel);
    @(negedge clk);
    if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
  endtask

  task automatic run_q(input bit sel, input bit poke);
    logic [14:0] e;
    int i = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      e = q.pop_front();
      chk(sel ? "trace_b" : "trace_a", 32'(obs(sel)), 32'(e));
      if (sel) last_hp_b = e[13:7]; else last_hp_a = e[13:7];
      bus_a.start = poke && i >= 2 && i < 20;
      bus_b.start = 1'b0;
      i++;
    end
  endtask

  task automatic stop_a(input bit check_hp);
    @(negedge clk);
    bus_a.stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_active", 32'(bus_a.active), 32'd0);
    chk("stop_busy",   32'(bus_a.busy),   32'd0);
    chk("stop_addr",   32'(bus_a.rom_addr), 32'd0);
    chk("stop_done",   32'(bus_a.done),   32'd0);
    if (check_hp) chk("stop_hp", 32'(bus_a.hp), 32'(last_hp_a));
    bus_a.stop = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("stop_idle", 32'({bus_a.busy, bus_a.done, bus_a.active}), 32'd0);
    end
  endtask

  task automatic basic_rom();
    foreach (rom_a[i]) rom_a[i] = 11'd0;
    rom_a[0] = w(7'd10, 4'd2);
    rom_a[1] = w(7'd20, 4'd1);
  endtask

  initial begin
    bus_a.start = 0; bus_a.stop = 0; bus_a.loop_en = 0;
    bus_b.start = 0; bus_b.stop = 0; bus_b.loop_en = 0;
    basic_rom();
    foreach (rom_b[i]) rom_b[i] = w(7'd5, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'(obs(0)), 32'd0);
    chk("rst_b", 32'(obs(1)), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_a", 32'(obs(0)), 32'd0);

    // basic tune
    kick(0); gen(0, 0, 500); run_q(0, 0);

    // rest word at address 0
    rom_a[0] = w(7'd0, 4'd3);
    kick(0); gen(0, 0, 500); run_q(0, 0);

    // looping basic tune, three passes, then abort
    basic_rom();
    bus_a.loop_en = 1'b1;
    kick(0); gen(0, 1, 1 + 3 * 23 + 5); run_q(0, 0);
    stop_a(1'b0);

    // empty tune while looping
    rom_a[0] = 11'd0;
    kick(0); gen(0, 1, 500); run_q(0, 0);
    bus_a.loop_en = 1'b0;

    // stop mid-note, then replay with start held during playback
    basic_rom();
    kick(0); gen(0, 0, 5); run_q(0, 0);
    stop_a(1'b1);
    kick(0); gen(0, 0, 500); run_q(0, 1);

    // address wrap, small ROM
    kick(1); gen(1, 0, 500); run_q(1, 0);
    bus_b.loop_en = 1'b1;
    kick(1); gen(1, 1, 60); run_q(1, 0);
    @(negedge clk) bus_b.stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_b", 32'({bus_b.busy, bus_b.active, bus_b.done, bus_b.rom_addr}), 32'd0);
    bus_b.stop = 1'b0;
    bus_b.loop_en = 1'b0;

    // asynchronous reset mid-note
    kick(0); gen(0, 0, 6); run_q(0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", 32'(obs(0)), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
